// File: rtl/zad_1.sv
// 3-to-6 one-hot decoder with a registered output. The combinational core is
// selectable (Zhegalkin polynomials, sum of minterms, or behavioural case).
module zad_1 #(
  parameter string Realization = "ZHEG"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] x,
  output logic [5:0] y
);

  logic [5:0] d;

  generate
    if (Realization == "ZHEG") begin : g_zheg
      logic x0, x1, x2;
      logic p01, p02, p12, p012;

      always_comb begin
        x0   = x[0];
        x1   = x[1];
        x2   = x[2];
        p01  = x0 & x1;
        p02  = x0 & x2;
        p12  = x1 & x2;
        p012 = x0 & x1 & x2;
      end

      // XOR-of-ANDs over GF(2); the constant term 1 appears only in d[0]
      always_comb begin
        d    = '0;
        d[0] = 1'b1 ^ x0 ^ x1 ^ x2 ^ p01 ^ p02 ^ p12 ^ p012;
        d[1] = x0 ^ p01 ^ p02 ^ p012;
        d[2] = x1 ^ p01 ^ p12 ^ p012;
        d[3] = p01 ^ p012;
        d[4] = x2 ^ p02 ^ p12 ^ p012;
        d[5] = p02 ^ p012;
      end
    end else if (Realization == "SOP") begin : g_sop
      always_comb begin
        d    = '0;
        d[0] = ~x[2] & ~x[1] & ~x[0];
        d[1] = ~x[2] & ~x[1] &  x[0];
        d[2] = ~x[2] &  x[1] & ~x[0];
        d[3] = ~x[2] &  x[1] &  x[0];
        d[4] =  x[2] & ~x[1] & ~x[0];
        d[5] =  x[2] & ~x[1] &  x[0];
      end
    end else if (Realization == "CASE") begin : g_case
      always_comb begin
        d = '0;
        case (x)
          3'd0:    d = 6'b000001;
          3'd1:    d = 6'b000010;
          3'd2:    d = 6'b000100;
          3'd3:    d = 6'b001000;
          3'd4:    d = 6'b010000;
          3'd5:    d = 6'b100000;
          default: d = '0;
        endcase
      end
    end else begin : g_bad
      $error("zad_1: unsupported Realization value");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) y <= '0;
    else        y <= d;
  end

endmodule

// File: tb/tb_zad_1.sv
// Directed bench for zad_1: runs all three realizations side by side and
// compares each against hand-computed one-hot codes.
module tb_zad_1;

  logic       clk;
  logic       rst_n;
  logic [2:0] x;
  logic [5:0] y_zheg, y_sop, y_case;

  int tests;
  int fails;

  zad_1 #(.Realization("ZHEG")) u_zheg (.clk(clk), .rst_n(rst_n), .x(x), .y(y_zheg));
  zad_1 #(.Realization("SOP"))  u_sop  (.clk(clk), .rst_n(rst_n), .x(x), .y(y_sop));
  zad_1 #(.Realization("CASE")) u_case (.clk(clk), .rst_n(rst_n), .x(x), .y(y_case));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [5:0] exp);
    check({tag, "/zheg"}, y_zheg, exp);
    check({tag, "/sop"},  y_sop,  exp);
    check({tag, "/case"}, y_case, exp);
  endtask

  // Apply inputs, then sample shortly after the following rising edge.
  task automatic step(input logic r, input logic [2:0] v);
    rst_n = r;
    x     = v;
    @(posedge clk);
    #1;
  endtask

  logic [5:0] sweep_exp [8];

  initial begin
    tests = 0;
    fails = 0;
    sweep_exp[0] = 6'b000001;
    sweep_exp[1] = 6'b000010;
    sweep_exp[2] = 6'b000100;
    sweep_exp[3] = 6'b001000;
    sweep_exp[4] = 6'b010000;
    sweep_exp[5] = 6'b100000;
    sweep_exp[6] = 6'b000000;
    sweep_exp[7] = 6'b000000;

    rst_n = 1'b0;
    x     = 3'd3;
    @(negedge clk);

    step(1'b0, 3'd3);
    check_all("reset1", 6'b000000);
    step(1'b0, 3'd3);
    check_all("reset2", 6'b000000);
    step(1'b1, 3'd3);
    check_all("release", 6'b001000);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'(i));
      check_all($sformatf("sweep%0d", i), sweep_exp[i]);
    end

    step(1'b1, 3'd6);
    check_all("code6", 6'b000000);
    step(1'b1, 3'd7);
    check_all("code7", 6'b000000);

    step(1'b1, 3'd5);
    check_all("stream5", 6'b100000);
    step(1'b0, 3'd5);
    check_all("midreset", 6'b000000);
    step(1'b1, 3'd1);
    check_all("rerelease", 6'b000010);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i));
      check_all($sformatf("equiv%0d", i), sweep_exp[i]);
      check($sformatf("sop_vs_zheg%0d", i),  y_sop,  y_zheg);
      check($sformatf("case_vs_zheg%0d", i), y_case, y_zheg);
    end

    step(1'b1, 3'bxxx);
    step(1'b1, 3'd2);
    check_all("after_x", 6'b000100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zad_1.md
# zad_1

3-to-6 one-hot decoder with a registered output and a selectable logic realization. A 3-bit code `x` in 0..5 asserts exactly one bit of `y`; codes 6 and 7 produce all-zero. The block is a leaf used to compare gate-level realizations (Zhegalkin/ANF, SOP, behavioural) of the same truth table. All realizations must be functionally identical.

## Interface
- `Realization`, default `"ZHEG"`: selects the combinational core.
  - `"ZHEG"`: Zhegalkin (XOR-of-ANDs) polynomials.
  - `"SOP"`: AND-OR of minterms.
  - `"CASE"`: behavioural case statement.
  - Any other value: elaboration error.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset; synchronous, active-low.
- `x`  input  3  code to decode; `x[2]` is the MSB.
- `y`  output  6  registered one-hot result; `y[i]` is high iff `x == i`.

## Operation
- Combinational core `d[5:0]`: `d[i] = (x == i)` for i = 0..5.
- Codes 6 and 7 give `d = 6'b000000`. Never more than one bit is high.
- `"ZHEG"` equations (`&` = AND, `^` = XOR):
  - d0 = 1 ^ x0 ^ x1 ^ x2 ^ x0x1 ^ x0x2 ^ x1x2 ^ x0x1x2
  - d1 = x0 ^ x0x1 ^ x0x2 ^ x0x1x2
  - d2 = x1 ^ x0x1 ^ x1x2 ^ x0x1x2
  - d3 = x0x1 ^ x0x1x2
  - d4 = x2 ^ x0x2 ^ x1x2 ^ x0x1x2
  - d5 = x0x2 ^ x0x1x2
- `"SOP"` uses one minterm per output, e.g. d4 = x2·~x1·~x0. `"CASE"` uses a full case with default 0.
- Output register: on each rising `clk` edge, if `rst_n == 0` then `y <= 0`, else `y <= d`.
- X/Z on `x`: no masking. Unknown inputs propagate as unknown to `y` in simulation. No defined value is required.

## Timing
- Reset value: `y = 6'b000000` at the first rising edge with `rst_n` low. `y` is undefined before the first clock.
- Latency: 1 cycle. `x` sampled at edge n appears on `y` after edge n. Throughput is 1 code per cycle.
- `rst_n` is sampled only at clock edges. Deasserting it mid-stream lets the next edge load `d` from the current `x`.
- If reset is asserted mid-operation, `y` clears at the next edge regardless of `x`.
- Reset has priority over data when both occur at the same edge.
- `x` must be stable for setup/hold around the `clk` edge. No other handshake.

## Test plan
- Reset: `rst_n = 0` for 2 cycles with `x = 3` -> `y = 000000`. Release with `x = 3` -> `y = 001000` one edge later.
- Sweep: `x = 0,1,2,3,4,5`, one per cycle -> `y = 000001, 000010, 000100, 001000, 010000, 100000`, each one cycle after its input.
- Unused codes: `x = 6`, then `x = 7` -> `y = 000000` both cycles.
- Mid-stream reset: stream `x = 5`, pull `rst_n` low for one edge -> `y = 000000`. Release with `x = 1` -> `y = 000010` next edge.
- Equivalence: instantiate `"ZHEG"`, `"SOP"` and `"CASE"` side by side and drive `x = 0..7` -> all three `y` identical every cycle.
- Unknown input: `x = 3'bxxx` -> `y` contains X one cycle later with no error. `x = 2` afterwards -> `y = 000100`.
